serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor built around a DIGIT-bit full-adder slice; the next generation of the single-bit full adder.
- Operands are latched on a start strobe, then processed least-significant digit first, one digit per clock, with the carry held in a register between digits.
- Provides area-cheap wide addition for the math library. Downstream blocks consume sum/cout on a one-cycle done pulse.

---
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: LSB digit first, carry held between digits.
// Result, carry-out and signed overflow are presented on a one-cycle done pulse.

module serial_adder_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_s,
  output logic         o_c,
  output logic         o_cmsb
);

  logic [W:0] w_c;

  assign w_c[0] = i_c;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic w_p;
    assign w_p      = i_a[i] ^ i_b[i];
    assign o_s[i]   = w_p ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_p & w_c[i]);
  end

  assign o_c    = w_c[W];
  assign o_cmsb = w_c[W-1];

endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic                   w_accept;
  logic                   w_last;
  logic [DIGIT-1:0]       w_ds;
  logic                   w_dc;
  logic                   w_cmsb;
  logic [WIDTH+DIGIT-1:0] w_cat;

  serial_adder_slice #(.W(DIGIT)) u_slice (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_c    (r_carry),
    .o_s    (w_ds),
    .o_c    (w_dc),
    .o_cmsb (w_cmsb)
  );

  assign w_accept = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == LAST);
  // New digit enters at the top; works even when WIDTH == DIGIT.
  assign w_cat    = {w_ds, r_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub ? ~cin : cin;
        r_cnt   <= '0;
        r_state <= S_RUN;
        r_busy  <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_sum   <= w_cat[WIDTH+DIGIT-1:DIGIT];
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_dc;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_cout  <= w_dc;
          r_ovf   <= w_cmsb ^ w_dc;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder across several digit sizes.
// Instances 0..2 are WIDTH=8 with DIGIT=1,2,4; instance 3 is WIDTH=4, DIGIT=1.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] start;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] a4;
  logic [3:0] b4;

  logic [2:0] busy8;
  logic [2:0] done8;
  logic [2:0] cout8;
  logic [2:0] ovf8;
  logic [7:0] sum8 [3];

  logic       busy4;
  logic       done4;
  logic       cout4;
  logic       ovf4;
  logic [3:0] sum4;

  int n_chk = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy8[0]), .done(done8[0]),
    .sum(sum8[0]), .cout(cout8[0]), .ovf(ovf8[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy8[1]), .done(done8[1]),
    .sum(sum8[1]), .cout(cout8[1]), .ovf(ovf8[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub),
    .a(a), .b(b), .cin(cin), .busy(busy8[2]), .done(done8[2]),
    .sum(sum8[2]), .cout(cout8[2]), .ovf(ovf8[2])
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .sub(sub),
    .a(a4), .b(b4), .cin(cin), .busy(busy4), .done(done4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    int         idx;
    logic       sb;
    logic [7:0] av;
    logic [7:0] bv;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         lat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input int idx, input logic sb,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic ci);
    @(negedge clk);
    a = av;
    b = bv;
    sub = sb;
    cin = ci;
    start[idx] = 1'b1;
    @(posedge clk);
    #1 start[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, output int lat, output int bc);
    lat = 0;
    bc = int'(busy8[idx]);
    while (!done8[idx] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      bc += int'(busy8[idx]);
    end
  endtask

  initial begin
    int lat;
    int bc;
    int t;
    int first;
    int second;
    bit seen;

    tbl[0] = '{0, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8};
    tbl[1] = '{1, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4};
    tbl[2] = '{2, 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, 2};
    tbl[3] = '{2, 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0, 2};
    tbl[4] = '{0, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 8};
    tbl[5] = '{1, 1'b0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 4};
    tbl[6] = '{2, 1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 2};
    tbl[7] = '{0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 8};
    tbl[8] = '{1, 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 4};
    tbl[9] = '{2, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 2};

    rst_n = 1'b0;
    start = '0;
    sub = 1'b0;
    cin = 1'b0;
    a = '0;
    b = '0;
    a4 = '0;
    b4 = '0;

    #12;
    chk("rst_busy8", {29'd0, busy8}, 32'd0);
    chk("rst_done8", {29'd0, done8}, 32'd0);
    chk("rst_cout8", {29'd0, cout8}, 32'd0);
    chk("rst_ovf8", {29'd0, ovf8}, 32'd0);
    chk("rst_sum_d1", {24'd0, sum8[0]}, 32'd0);
    chk("rst_sum_d4", {24'd0, sum8[2]}, 32'd0);
    chk("rst_w4", {24'd0, busy4, done4, cout4, ovf4, sum4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].idx, tbl[i].sb, tbl[i].av, tbl[i].bv, tbl[i].ci);
      wait_done(tbl[i].idx, lat, bc);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_busy", i), bc, tbl[i].lat);
      chk($sformatf("v%0d_sum", i), {24'd0, sum8[tbl[i].idx]},
          {24'd0, tbl[i].s});
      chk($sformatf("v%0d_cout", i), {31'd0, cout8[tbl[i].idx]},
          {31'd0, tbl[i].co});
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf8[tbl[i].idx]},
          {31'd0, tbl[i].ov});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done8[tbl[i].idx]},
          32'd0);
      chk($sformatf("v%0d_hold", i), {24'd0, sum8[tbl[i].idx]},
          {24'd0, tbl[i].s});
    end

    // start during RUN must be ignored
    launch(0, 1'b0, 8'h21, 8'h13, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    a = 8'hFF;
    b = 8'hFF;
    sub = 1'b1;
    cin = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    t = 4;
    while (!done8[0] && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("ign_latency", t, 8);
    chk("ign_sum", {24'd0, sum8[0]}, 32'h34);
    chk("ign_cout", {31'd0, cout8[0]}, 32'd0);
    chk("ign_ovf", {31'd0, ovf8[0]}, 32'd0);

    // start held high: chains through DONE with no idle cycle
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    sub = 1'b0;
    cin = 1'b0;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    t = 0;
    first = -1;
    second = -1;
    while (second < 0 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
      if (done8[0]) begin
        if (first < 0) begin
          first = t;
          chk("chain_sum1", {24'd0, sum8[0]}, 32'h03);
          a = 8'h10;
          b = 8'h20;
        end else begin
          second = t;
          chk("chain_sum2", {24'd0, sum8[0]}, 32'h30);
        end
      end
    end
    start[0] = 1'b0;
    chk("chain_first", first, 8);
    chk("chain_gap", second - first, 9);

    // asynchronous reset mid-run
    launch(0, 1'b0, 8'hFF, 8'hFF, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy_pre", {31'd0, busy8[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        {22'd0, busy8[0], done8[0], sum8[0], cout8[0], ovf8[0]}, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done8[0] || busy8[0]) seen = 1'b1;
    end
    chk("mid_no_done", {31'd0, seen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(0, 1'b0, 8'h12, 8'h34, 1'b0);
    wait_done(0, lat, bc);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_sum", {24'd0, sum8[0]}, 32'h46);

    // exhaustive WIDTH=4 sweep against an arithmetic model
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          for (int c = 0; c < 2; c++) begin
            int sx;
            int sy;
            int ures;
            int sres;
            logic [5:0] exp6;
            @(negedge clk);
            a4 = 4'(x);
            b4 = 4'(y);
            sub = s[0];
            cin = c[0];
            start[3] = 1'b1;
            @(posedge clk);
            #1 start[3] = 1'b0;
            t = 0;
            while (!done4 && t < 20) begin
              @(posedge clk);
              #1;
              t++;
            end
            sx = (x >= 8) ? x - 16 : x;
            sy = (y >= 8) ? y - 16 : y;
            if (s == 0) begin
              ures = x + y + c;
              sres = sx + sy + c;
              exp6[4] = (ures > 15);
            end else begin
              ures = x - y - c;
              sres = sx - sy - c;
              exp6[4] = (ures >= 0);
            end
            exp6[3:0] = 4'(ures);
            exp6[5] = (sres < -8) || (sres > 7);
            chk($sformatf("sweep s%0d a%0h b%0h c%0d", s, x, y, c),
                {26'd0, (t == 4) ? {ovf4, cout4, sum4} : 6'h3F},
                {26'd0, exp6});
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
